// File: rtl/sys_mem_responder.sv
// sys_mem_responder: system-bus target holding a word-addressed backing memory.
// Accepts one strobed read or write while idle, spends WAIT_STATES wait cycles,
// then returns read data (SysDataOE + SysReady) or acknowledges a write (SysReady).
//
// Ports:
//   clock       single system clock, rising edge
//   reset       synchronous, active-high; does not clear the memory array
//   SysStrobe   one-cycle request strobe from the initiator
//   SysRW       direction, RW_READ / RW_WRITE
//   SysAddr     word address, sampled in the strobe cycle
//   SysDataIn   write data, sampled in the strobe cycle
//   SysDataOut  read data, held between reads; qualify with SysDataOE
//   SysDataOE   one-cycle pulse while SysDataOut carries read data
//   SysReady    one-cycle completion pulse for read or write
//   SysBusy     high in every non-IDLE state
//   SysErr      sticky: strobe seen while not IDLE, cleared only by reset
module sys_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 2   // 0..3, fits the 2-bit wait counter
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SysStrobe,
    input  logic                  SysRW,
    input  logic [ADDR_WIDTH-1:0] SysAddr,
    input  logic [DATA_WIDTH-1:0] SysDataIn,
    output logic [DATA_WIDTH-1:0] SysDataOut,
    output logic                  SysDataOE,
    output logic                  SysReady,
    output logic                  SysBusy,
    output logic                  SysErr
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 2;

    // Shared bus direction encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Counter is loaded with WAIT_STATES-1 so it reaches zero in the last wait cycle
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES == 0) ? CNT_W'(0) : CNT_W'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ_WAIT  = 3'd1,
        ST_READ_DATA  = 3'd2,
        ST_WRITE_WAIT = 3'd3,
        ST_WRITE_DONE = 3'd4
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  oe_q,       oe_d;
    logic                  ready_q,    ready_d;
    logic                  busy_q,     busy_d;
    logic                  err_q,      err_d;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;

    // Next-state, counter, address latch and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        mem_we_c   = 1'b0;
        rd_addr_c  = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (SysStrobe) begin
                    cnt_d = CNT_LOAD;
                    if (SysRW == RW_READ) begin
                        addr_d    = SysAddr;
                        // With no wait states the data is fetched at the strobe edge itself
                        rd_addr_c = SysAddr;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_READ_DATA;
                        end else begin
                            state_d = ST_READ_WAIT;
                        end
                    end else begin
                        mem_we_c = 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_WRITE_DONE;
                        end else begin
                            state_d = ST_WRITE_WAIT;
                        end
                    end
                end
            end
            ST_READ_WAIT: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_READ_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE_WAIT: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_WRITE_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READ_DATA:  state_d = ST_IDLE;
            ST_WRITE_DONE: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        // A strobe outside IDLE is dropped but remembered
        if (SysStrobe && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        // Read data is captured on entry to READ_DATA and then held
        if (state_d == ST_READ_DATA) begin
            data_out_d = mem_q[rd_addr_c];
        end

        oe_d    = (state_d == ST_READ_DATA);
        ready_d = (state_d == ST_READ_DATA) || (state_d == ST_WRITE_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_out_q <= '0;
            oe_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Backing array: not reset, and a write in a reset cycle is suppressed
    always_ff @(posedge clock) begin
        if (!reset && mem_we_c) begin
            mem_q[SysAddr] <= SysDataIn;
        end
    end

    assign SysDataOut = data_out_q;
    assign SysDataOE  = oe_q;
    assign SysReady   = ready_q;
    assign SysBusy    = busy_q;
    assign SysErr     = err_q;

endmodule
